// File: rtl/bpred_ram_scheduler_pkg.sv
// rtl/bpred_ram_scheduler_pkg.sv - shared types and helpers for the predictor RAM scheduler
package bpred_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_PRED_RD = 3'd2,
    ST_UPD_RD  = 3'd3,
    ST_UPD_WR  = 3'd4
  } bpred_st_t;

  // Right-shift by (32-N) to get the weakly-not-taken value 2^(N-1)-1 for any width N.
  localparam logic [31:0] WEAK_NT = 32'h7FFF_FFFF;

  function automatic logic [31:0] sat_ctr(input logic [31:0] ctr, input logic up,
                                          input int unsigned n);
    logic [31:0] lim;
    lim = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    if (up) begin
      return (ctr >= lim) ? lim : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bpred_ram_scheduler_if.sv
// rtl/bpred_ram_scheduler_if.sv - request, response and RAM strobe bundle of the scheduler
interface bpred_ram_scheduler_if #(
  parameter int R = 4,
  parameter int M = 2
) ();
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic             pred_ready;
  logic             pred_resp_valid;
  logic             pred_taken;
  logic             upd_valid;
  logic             upd_taken;
  logic             upd_ready;
  logic [R+M-1:0]   ram_addr;
  logic             ram_cs;
  logic             ram_oe;
  logic             ram_we;
  logic [M-1:0]     ghr;
  logic             init_done;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_taken,
    input  pred_ready, pred_resp_valid, pred_taken, upd_ready,
    input  ram_addr, ram_cs, ram_oe, ram_we, ghr, init_done
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_taken,
    output pred_ready, pred_resp_valid, pred_taken, upd_ready,
    output ram_addr, ram_cs, ram_oe, ram_we, ghr, init_done
  );
endinterface

// File: rtl/bpred_pend_fifo.sv
// rtl/bpred_pend_fifo.sv - in-order queue of RAM addresses for predictions awaiting update
module bpred_pend_fifo #(
  parameter int W = 6,
  parameter int Q = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [W-1:0]          i_din,
  input  logic                  i_pop,
  output logic [W-1:0]          o_dout,
  output logic [$clog2(Q):0]    o_count,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int AW = $clog2(Q);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [Q];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(Q));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end
endmodule

// File: rtl/bpred_ram_scheduler.sv
// rtl/bpred_ram_scheduler.sv - single-port counter RAM sequencer with GHR and init sweep
module bpred_ram_scheduler
  import bpred_pkg::*;
#(
  parameter int R = 4,
  parameter int M = 2,
  parameter int N = 2,
  parameter int Q = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  bpred_ram_scheduler_if.slave    bus,
  inout  wire  [N-1:0]            ram_data
);
  localparam int AW = R + M;
  localparam int CW = $clog2(Q) + 1;
  localparam logic [N-1:0] INIT_CTR = N'(WEAK_NT >> (32 - N));

  bpred_st_t     r_state;
  logic [AW:0]   r_sweep;
  logic [M-1:0]  r_ghr;
  logic [AW-1:0] r_addr;
  logic          r_cs;
  logic          r_oe;
  logic          r_we;
  logic [N-1:0]  r_wdata;
  logic          r_upd_taken;
  logic          r_resp_valid;
  logic          r_taken;
  logic          r_init_done;

  logic          w_idle;
  logic          w_pred_ready;
  logic          w_upd_ready;
  logic          w_pred_fire;
  logic          w_upd_fire;
  logic [AW-1:0] w_pred_addr;
  logic [AW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_unused_count;
  logic          w_unused_pc;
  logic [N-1:0]  w_ctr_next;
  logic [M-1:0]  w_ghr_next;

  bpred_pend_fifo #(.W(AW), .Q(Q)) u_pend_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_pred_fire),
    .i_din   (w_pred_addr),
    .i_pop   (r_state == ST_UPD_WR),
    .o_dout  (w_head),
    .o_count (w_unused_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A waiting update always wins so the queue can drain even when lookups stream.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_upd_ready  = w_idle & ~w_empty;
  assign w_pred_ready = w_idle & ~w_full & ~(bus.upd_valid & ~w_empty);
  assign w_upd_fire   = bus.upd_valid & w_upd_ready;
  assign w_pred_fire  = bus.pred_valid & w_pred_ready;
  assign w_pred_addr  = {r_ghr, bus.pred_pc[R+1:2]};
  assign w_unused_pc  = ^{bus.pred_pc[31:R+2], bus.pred_pc[1:0]};
  assign w_ctr_next   = N'(sat_ctr(32'(ram_data), r_upd_taken, N));
  assign w_ghr_next   = (r_ghr << 1) | M'(r_upd_taken);

  assign bus.pred_ready      = w_pred_ready;
  assign bus.upd_ready       = w_upd_ready;
  assign bus.pred_resp_valid = r_resp_valid;
  assign bus.pred_taken      = r_taken;
  assign bus.ram_addr        = r_addr;
  assign bus.ram_cs          = r_cs;
  assign bus.ram_oe          = r_oe;
  assign bus.ram_we          = r_we;
  assign bus.ghr             = r_ghr;
  assign bus.init_done       = r_init_done;

  assign ram_data = r_we ? r_wdata : {N{1'bz}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_INIT;
      r_sweep      <= '0;
      r_ghr        <= '0;
      r_addr       <= '0;
      r_cs         <= 1'b0;
      r_oe         <= 1'b0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_upd_taken  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_taken      <= 1'b0;
      r_init_done  <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_cs         <= 1'b0;
      r_oe         <= 1'b0;
      r_we         <= 1'b0;
      case (r_state)
        ST_INIT: begin
          // The extra MSB of the sweep pointer marks that every address has been written.
          if (r_sweep[AW]) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
          end else begin
            r_addr  <= r_sweep[AW-1:0];
            r_wdata <= INIT_CTR;
            r_cs    <= 1'b1;
            r_we    <= 1'b1;
            r_sweep <= r_sweep + (AW+1)'(1);
          end
        end
        ST_IDLE: begin
          if (w_upd_fire) begin
            r_addr      <= w_head;
            r_upd_taken <= bus.upd_taken;
            r_cs        <= 1'b1;
            r_oe        <= 1'b1;
            r_state     <= ST_UPD_RD;
          end else if (w_pred_fire) begin
            r_addr  <= w_pred_addr;
            r_cs    <= 1'b1;
            r_oe    <= 1'b1;
            r_state <= ST_PRED_RD;
          end
        end
        ST_PRED_RD: begin
          r_resp_valid <= 1'b1;
          r_taken      <= ram_data[N-1];
          r_state      <= ST_IDLE;
        end
        ST_UPD_RD: begin
          r_wdata <= w_ctr_next;
          r_cs    <= 1'b1;
          r_we    <= 1'b1;
          r_state <= ST_UPD_WR;
        end
        ST_UPD_WR: begin
          r_ghr   <= w_ghr_next;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end
endmodule
